// File: rtl/tag_lookup_ctrl.sv
// Two-way set-associative tag lookup controller: compare, refill on miss, LRU victim select, flush sweep.
// Hit response 2 cycles after acceptance; req_ready drops outside IDLE and while flush_start is high.
module tag_lookup_ctrl #(
    parameter int AWIDTH = 3,
    parameter int TWIDTH = 15
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [AWIDTH+TWIDTH-1:0] req_addr,
    output logic                     resp_valid,
    output logic                     resp_hit,
    output logic                     resp_way,
    output logic                     refill_req,
    output logic [AWIDTH+TWIDTH-1:0] refill_addr,
    input  logic                     refill_ack,
    input  logic                     flush_start,
    output logic                     flush_busy,
    output logic [AWIDTH-1:0]        t_addr,
    output logic [TWIDTH:0]          t_din,
    output logic                     t0_we,
    output logic                     t1_we,
    input  logic [TWIDTH:0]          t0_dout,
    input  logic [TWIDTH:0]          t1_dout
);

    localparam int DEPTH = 1 << AWIDTH;

    typedef enum logic [2:0] {IDLE, COMPARE, REFILL, WRITE, RESP, FLUSH} state_t;

    state_t                    state, state_nxt;
    logic [AWIDTH+TWIDTH-1:0]  addr_q;
    logic [DEPTH-1:0]          lru;
    logic [AWIDTH-1:0]         flush_cnt;
    logic                      victim_q;
    logic                      resp_hit_q;
    logic                      resp_way_q;

    logic [AWIDTH-1:0]         idx;
    logic [TWIDTH-1:0]         tag_q;
    logic                      hit0, hit1, victim_sel;

    assign idx   = addr_q[AWIDTH-1:0];
    assign tag_q = addr_q[AWIDTH+TWIDTH-1:AWIDTH];
    assign hit0  = t0_dout[TWIDTH] && (t0_dout[TWIDTH-1:0] == tag_q);
    assign hit1  = t1_dout[TWIDTH] && (t1_dout[TWIDTH-1:0] == tag_q);

    // Fill an empty way before evicting; only a fully valid set consults LRU.
    assign victim_sel = !t0_dout[TWIDTH] ? 1'b0 :
                        !t1_dout[TWIDTH] ? 1'b1 : lru[idx];

    assign refill_addr = addr_q;
    assign resp_hit    = resp_hit_q;
    assign resp_way    = resp_way_q;

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        t_addr     = idx;
        t_din      = '0;
        t0_we      = 1'b0;
        t1_we      = 1'b0;
        refill_req = 1'b0;
        flush_busy = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                // Present the incoming index so tag data is ready in COMPARE.
                req_ready = !flush_start;
                t_addr    = req_addr[AWIDTH-1:0];
                if (flush_start)
                    state_nxt = FLUSH;
                else if (req_valid)
                    state_nxt = COMPARE;
            end
            COMPARE: state_nxt = (hit0 || hit1) ? RESP : REFILL;
            REFILL: begin
                refill_req = 1'b1;
                if (refill_ack)
                    state_nxt = WRITE;
            end
            WRITE: begin
                t_din     = {1'b1, tag_q};
                t0_we     = !victim_q;
                t1_we     = victim_q;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            FLUSH: begin
                flush_busy = 1'b1;
                t_addr     = flush_cnt;
                t0_we      = 1'b1;
                t1_we      = 1'b1;
                if (&flush_cnt)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            lru        <= '0;
            flush_cnt  <= '0;
            victim_q   <= 1'b0;
            resp_hit_q <= 1'b0;
            resp_way_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready)
                        addr_q <= req_addr;
                end
                COMPARE: begin
                    if (hit0 || hit1) begin
                        // Way 0 wins a double hit; LRU then points at the other way.
                        resp_hit_q <= 1'b1;
                        resp_way_q <= !hit0;
                        lru[idx]   <= hit0;
                    end else begin
                        victim_q <= victim_sel;
                    end
                end
                WRITE: begin
                    resp_hit_q <= 1'b0;
                    resp_way_q <= victim_q;
                    lru[idx]   <= ~victim_q;
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt + 1'b1;
                    lru       <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Directed bench for tag_lookup_ctrl with a behavioural two-way tag RAM (1-cycle read latency).
module tb_tag_lookup_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [17:0] req_addr = '0;
    logic        resp_valid, resp_hit, resp_way;
    logic        refill_req;
    logic [17:0] refill_addr;
    logic        refill_ack = 1'b0;
    logic        flush_start = 1'b0;
    logic        flush_busy;
    logic [2:0]  t_addr;
    logic [15:0] t_din;
    logic        t0_we, t1_we;
    logic [15:0] t0_dout, t1_dout;

    logic [15:0] mem0 [8];
    logic [15:0] mem1 [8];
    logic        pl_we0 = 1'b0, pl_we1 = 1'b0;
    logic [2:0]  pl_addr = '0;
    logic [15:0] pl_dat = '0;
    int          we_cnt = 0;

    int n_checks = 0;
    int n_fail   = 0;

    tag_lookup_ctrl #(.AWIDTH(3), .TWIDTH(15)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
        .refill_req(refill_req), .refill_addr(refill_addr), .refill_ack(refill_ack),
        .flush_start(flush_start), .flush_busy(flush_busy),
        .t_addr(t_addr), .t_din(t_din), .t0_we(t0_we), .t1_we(t1_we),
        .t0_dout(t0_dout), .t1_dout(t1_dout)
    );

    always #5 clock = ~clock;

    // Tag RAM: synchronous read of the address presented at the edge; bench preload port.
    always @(posedge clock) begin
        if (t0_we) mem0[t_addr] <= t_din;
        if (t1_we) mem1[t_addr] <= t_din;
        if (pl_we0) mem0[pl_addr] <= pl_dat;
        if (pl_we1) mem1[pl_addr] <= pl_dat;
        if (t0_we || t1_we) we_cnt <= we_cnt + 1;
        t0_dout <= mem0[t_addr];
        t1_dout <= mem1[t_addr];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic preload(input logic w0, input logic w1, input logic [2:0] a, input logic [15:0] d);
        pl_we0 = w0; pl_we1 = w1; pl_addr = a; pl_dat = d;
        tick();
        pl_we0 = 1'b0; pl_we1 = 1'b0;
    endtask

    task automatic wait_resp(output logic hit, output logic way, output logic saw0, output logic saw1);
        int n;
        n = 0; saw0 = 1'b0; saw1 = 1'b0;
        while (!resp_valid && n < 50) begin
            refill_ack = refill_req;
            saw0 |= t0_we;
            saw1 |= t1_we;
            tick();
            n++;
        end
        refill_ack = 1'b0;
        check("resp_timeout", {31'd0, resp_valid}, 32'd1);
        hit = resp_hit;
        way = resp_way;
        tick();
    endtask

    task automatic run_req(input logic [14:0] tag, input logic [2:0] idx,
                           output logic hit, output logic way, output logic saw0, output logic saw1);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_addr  = {tag, idx};
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        check("accept_timeout", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        wait_resp(hit, way, saw0, saw1);
    endtask

    initial begin
        logic h, w, s0, s1;
        int   we_before;

        // Reset state; clear RAM through the preload port meanwhile.
        for (int i = 0; i < 8; i++) preload(1'b1, 1'b1, 3'(i), 16'h0000);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_hit_way", {30'd0, resp_hit, resp_way}, 32'd0);
        check("rst_refill_req", {31'd0, refill_req}, 32'd0);
        check("rst_refill_addr", {14'd0, refill_addr}, 32'd0);
        check("rst_flush_busy", {31'd0, flush_busy}, 32'd0);
        check("rst_we", {30'd0, t0_we, t1_we}, 32'd0);
        reset = 1'b0;
        preload(1'b1, 1'b0, 3'd2, 16'h9234);

        // Hit in way 0, index 2.
        req_valid = 1'b1;
        req_addr  = {15'h1234, 3'd2};
        #0;
        check("hit_ready", {31'd0, req_ready}, 32'd1);
        check("hit_taddr", {29'd0, t_addr}, 32'd2);
        tick();
        req_valid = 1'b0;
        check("hit_cmp_no_resp", {30'd0, resp_valid, req_ready}, 32'd0);
        tick();
        check("hit_resp", {29'd0, resp_valid, resp_hit, resp_way}, 32'b110);
        check("hit_lru2", {31'd0, dut.lru[2]}, 32'd1);
        tick();
        check("hit_done", {30'd0, resp_valid, req_ready}, 32'b01);

        // Miss at index 5, both ways invalid; ack after 4 cycles of refill_req.
        req_valid = 1'b1;
        req_addr  = {15'h0042, 3'd5};
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("refill_req_held", {31'd0, refill_req}, 32'd1);
            check("refill_addr", {14'd0, refill_addr}, {14'd0, 15'h0042, 3'd5});
            if (i == 3) refill_ack = 1'b1;
            tick();
        end
        refill_ack = 1'b0;
        check("wr_we", {30'd0, t0_we, t1_we}, 32'b10);
        check("wr_taddr", {29'd0, t_addr}, 32'd5);
        check("wr_tdin", {16'd0, t_din}, 32'h8042);
        check("wr_refill_drop", {31'd0, refill_req}, 32'd0);
        tick();
        check("miss_resp", {29'd0, resp_valid, resp_hit, resp_way}, 32'b100);
        check("miss_mem0_5", {16'd0, mem0[5]}, 32'h8042);
        check("miss_lru5", {31'd0, dut.lru[5]}, 32'd1);
        tick();

        // Index 1 full; hit way 0 sets lru[1]=1, then miss evicts way 1.
        preload(1'b1, 1'b1, 3'd1, 16'h8111);
        preload(1'b0, 1'b1, 3'd1, 16'h8222);
        run_req(15'h0111, 3'd1, h, w, s0, s1);
        check("idx1_hit_w0", {30'd0, h, w}, 32'b10);
        check("idx1_lru_1", {31'd0, dut.lru[1]}, 32'd1);
        run_req(15'h0333, 3'd1, h, w, s0, s1);
        check("idx1_miss_way1", {30'd0, h, w}, 32'b01);
        check("idx1_we_seen", {30'd0, s0, s1}, 32'b01);
        check("idx1_lru_0", {31'd0, dut.lru[1]}, 32'd0);
        check("idx1_mem1", {16'd0, mem1[1]}, 32'h8333);
        check("idx1_mem0_kept", {16'd0, mem0[1]}, 32'h8111);
        run_req(15'h0333, 3'd1, h, w, s0, s1);
        check("idx1_hit_w1", {30'd0, h, w}, 32'b11);
        check("idx1_lru_after_w1", {31'd0, dut.lru[1]}, 32'd0);

        // Flush sweep.
        flush_start = 1'b1;
        #0;
        check("flush_ready_low", {31'd0, req_ready}, 32'd0);
        tick();
        flush_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("flush_busy", {31'd0, flush_busy}, 32'd1);
            check("flush_taddr", {29'd0, t_addr}, 32'(i));
            check("flush_we_din", {14'd0, t0_we, t1_we, t_din}, {14'd0, 2'b11, 16'h0000});
            check("flush_ready", {31'd0, req_ready}, 32'd0);
            tick();
        end
        check("flush_end", {30'd0, flush_busy, req_ready}, 32'b01);
        check("flush_lru", {24'd0, dut.lru}, 32'd0);
        run_req(15'h1234, 3'd2, h, w, s0, s1);
        check("post_flush_miss", {30'd0, h, w}, 32'b00);

        // Flush and request together: flush wins, request taken after sweep.
        flush_start = 1'b1;
        req_valid   = 1'b1;
        req_addr    = {15'h0007, 3'd3};
        #0;
        check("both_ready_low", {31'd0, req_ready}, 32'd0);
        tick();
        flush_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("both_sweep", {30'd0, flush_busy, req_ready}, 32'b10);
            tick();
        end
        check("both_accept", {30'd0, flush_busy, req_ready}, 32'b01);
        tick();
        req_valid = 1'b0;
        check("both_taken", {31'd0, req_ready}, 32'd0);
        wait_resp(h, w, s0, s1);
        check("both_resp", {30'd0, h, w}, 32'b00);

        // Reset during refill.
        req_valid = 1'b1;
        req_addr  = {15'h0055, 3'd6};
        tick();
        req_valid = 1'b0;
        tick();
        check("rr_refill", {31'd0, refill_req}, 32'd1);
        we_before = we_cnt;
        reset = 1'b1;
        #1;
        check("rr_refill_drop", {31'd0, refill_req}, 32'd0);
        check("rr_we", {30'd0, t0_we, t1_we}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        #0;
        check("rr_ready", {31'd0, req_ready}, 32'd1);
        tick();
        tick();
        check("rr_no_write", 32'(we_cnt), 32'(we_before));
        check("rr_mem6", {mem0[6], mem1[6]}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tag_lookup_ctrl.md
TAG_LOOKUP_CTRL -- requirements
Module: tag_lookup_ctrl

Interface
REQ-001 SHALL have parameter AWIDTH, default 3, meaning index width; tag RAM depth = 1<<AWIDTH.
REQ-002 SHALL have parameter TWIDTH, default 15, meaning tag width; tag RAM word = {valid, tag}, TWIDTH+1 bits.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clock  in  1  rising-edge clock; reset  in  1  asynchronous active-high reset.
REQ-004 SHALL have the following requester ports.
- req_valid  in  1  lookup request
- req_ready  out  1  request accepted when high with req_valid
- req_addr  in  AWIDTH+TWIDTH  {tag, index}
- resp_valid  out  1  one-cycle response strobe
- resp_hit  out  1  1 = hit, 0 = miss and refilled
- resp_way  out  1  way hit or filled
REQ-005 SHALL have the following refill ports.
- refill_req  out  1  refill request, held until ack
- refill_addr  out  AWIDTH+TWIDTH  missing address
- refill_ack  in  1  refill complete
REQ-006 SHALL have the following flush ports.
- flush_start  in  1  invalidate all entries
- flush_busy  out  1  sweep in progress
REQ-007 SHALL have the following tag RAM ports; both ways share the address.
- t_addr  out  AWIDTH  address to both ways
- t_din  out  TWIDTH+1  write data
- t0_we  out  1  way 0 write enable
- t1_we  out  1  way 1 write enable
- t0_dout  in  TWIDTH+1  way 0 read data
- t1_dout  in  TWIDTH+1  way 1 read data

Function
REQ-008 SHALL implement these states: IDLE, COMPARE, REFILL, WRITE, RESP, FLUSH.
REQ-009 In IDLE, req_ready SHALL equal !flush_start, and t_addr SHALL equal the req_addr index combinationally. This matches tag RAM read latency: address latched at an edge, data valid the following cycle.
REQ-010 flush_start in IDLE SHALL have priority over req_valid.
- FLUSH entered, request not accepted.
- flush_start outside IDLE ignored.
REQ-011 On req_valid && req_ready, the controller SHALL latch req_addr and move IDLE -> COMPARE.
REQ-012 COMPARE SHALL evaluate hit per way as dout[TWIDTH] && dout[TWIDTH-1:0] == latched tag. If both ways hit, way 0 wins.
REQ-013 COMPARE on hit SHALL move to RESP, record way w, and set lru[index] = ~w.
REQ-014 COMPARE on miss SHALL choose the victim, then move to REFILL.
- Way 0 if way 0 is invalid.
- Else way 1 if way 1 is invalid.
- Else lru[index].
REQ-015 In REFILL, refill_req SHALL be 1 and refill_addr SHALL be the latched address, held stable until the cycle refill_ack=1, then move to WRITE. refill_ack outside REFILL is ignored.
REQ-016 WRITE SHALL last one cycle, then move to RESP with resp_hit=0, resp_way=victim.
- t_addr = index, t_din = {1'b1, tag}.
- Victim way's we = 1, other we = 0.
- lru[index] = ~victim.
REQ-017 RESP SHALL assert resp_valid for exactly one cycle with registered resp_hit/resp_way, then move to IDLE. Hit response appears 2 cycles after the accepting edge.
REQ-018 FLUSH SHALL sweep t_addr 0..DEPTH-1, one index per cycle.
- t0_we = t1_we = 1, t_din = 0.
- All lru bits cleared.
- flush_busy = 1 throughout.
- Counter wrap from DEPTH-1 returns to IDLE.
REQ-019 req_ready SHALL be 0 in every state other than IDLE.
REQ-020 t0_we and t1_we SHALL be 0 except in WRITE and FLUSH.
REQ-021 The lru array (DEPTH bits) SHALL be internal registers.

Reset
REQ-022 reset SHALL asynchronously force the following.
- State = IDLE, lru = 0, flush counter = 0.
- resp_valid, resp_hit, resp_way, refill_req, flush_busy, t0_we, t1_we = 0.
- refill_addr = 0.
REQ-023 Reset mid-REFILL or mid-FLUSH SHALL abort with no further tag write. Tag RAM contents are not cleared by reset.

Verification
REQ-024 Way 0 index 2 holds 0x9234; request {0x1234, 2} -> resp_valid 2 cycles later, hit=1, way=0, lru[2]=1.
REQ-025 Index 5 has both ways invalid; request tag 0x0042 -> refill_req held 4 cycles until ack; one cycle t0_we=1, t_addr=5, t_din=0x8042; then resp hit=0, way=0.
REQ-026 Index 1 has both ways valid, no match, lru[1]=1 -> t1_we written; resp way=1; lru[1]=0.
REQ-027 flush_start in IDLE -> flush_busy for 8 cycles, t_addr 0..7 with both we=1 and din=0, req_ready=0; the REQ-024 request then misses.
REQ-028 flush_start and req_valid together in IDLE -> flush wins, req_ready=0; request accepted the cycle after the sweep ends.
REQ-029 reset during REFILL -> refill_req=0 immediately, no we pulse; req_ready=1 the first cycle after release.
